// File: rtl/i2c_eeprom_slave_if.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave_if
// Memory-side bus of the I2C EEPROM responder.
//   mem_wr_en    one-cycle write strobe
//   mem_rd_en    one-cycle read strobe
//   mem_addr     byte address for either strobe
//   mem_wr_data  write data, valid with mem_wr_en
//   mem_rd_data  read data, valid the cycle after mem_rd_en
// master: the I2C responder (issues strobes); slave: the memory behind it.
// ---------------------------------------------------------------------------
interface i2c_eeprom_slave_if;
  logic        mem_wr_en;
  logic        mem_rd_en;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wr_data;
  logic [7:0]  mem_rd_data;

  modport master (
    output mem_wr_en,
    output mem_rd_en,
    output mem_addr,
    output mem_wr_data,
    input  mem_rd_data
  );

  modport slave (
    input  mem_wr_en,
    input  mem_rd_en,
    input  mem_addr,
    input  mem_wr_data,
    output mem_rd_data
  );
endinterface

// File: rtl/i2c_eeprom_slave.sv
// ---------------------------------------------------------------------------
// i2c_eeprom_slave
// I2C responder that looks like a 24xx-style EEPROM to the bus master and
// turns byte transfers into single-cycle strobes on a simple memory bus.
//   sys_clk    50 MHz system clock, the only clock used
//   sys_rst_n  synchronous active-low reset
//   i2c_scl    bus clock (asynchronous, oversampled)
//   i2c_sda    open-drain bus data, driven only to 0 or Z
//   mem        memory bus (strobes, address, write/read data)
//   busy       high from a detected START to a detected STOP
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | not addressed; bus ignored until the next START
// DEV_ADDR | shifting in the device address + R/W bit
// ACK_DEV  | driving ACK for the device address
// ADDR_H   | shifting in the high word-address byte
// ACK_AH   | driving ACK for the high address byte
// ADDR_L   | shifting in the low word-address byte
// ACK_AL   | driving ACK for the low address byte
// WR_DATA  | shifting in a write data byte (written on its 8th SCL rise)
// ACK_WR   | driving ACK for a write data byte
// RD_DATA  | driving a read byte MSB first
// RD_ACK   | SDA released, sampling the master's ACK/NACK
// ---------------------------------------------------------------------------
module i2c_eeprom_slave #(
  parameter logic [6:0] DEVICE_ADDR = 7'b1010_011,
  parameter bit         ADDR_NUM    = 1'b1
) (
  input  logic                       sys_clk,
  input  logic                       sys_rst_n,
  input  logic                       i2c_scl,
  inout  wire                        i2c_sda,
  i2c_eeprom_slave_if.master         mem,
  output logic                       busy
);

  typedef enum logic [3:0] {
    IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL,
    WR_DATA, ACK_WR, RD_DATA, RD_ACK
  } state_e;

  state_e      state_q;
  logic        scl_s1_q, scl_s2_q, scl_prev_q;
  logic        sda_s1_q, sda_s2_q, sda_prev_q;
  logic [3:0]  bit_cnt_q;
  logic [7:0]  shift_q;
  logic [15:0] ptr_q;
  logic        sda_oe_q;
  logic        busy_q;
  logic        master_ack_q;
  logic [1:0]  rd_phase_q;
  logic        mem_wr_en_q, mem_rd_en_q;
  logic [15:0] mem_addr_q;
  logic [7:0]  mem_wr_data_q;

  logic        scl_rise, scl_fall, sda_rise, sda_fall;
  logic        start_det, stop_det;
  logic [7:0]  byte_in;
  logic [15:0] ptr_inc;

  assign scl_rise  = scl_s2_q & ~scl_prev_q;
  assign scl_fall  = ~scl_s2_q & scl_prev_q;
  assign sda_rise  = sda_s2_q & ~sda_prev_q;
  assign sda_fall  = ~sda_s2_q & sda_prev_q;
  // SCL must be high on both sides of the SDA edge to be a bus condition.
  assign start_det = sda_fall & scl_s2_q & scl_prev_q;
  assign stop_det  = sda_rise & scl_s2_q & scl_prev_q;
  assign byte_in   = {shift_q[6:0], sda_s2_q};
  // One-byte addressing keeps the pointer inside 0x0000..0x00FF.
  assign ptr_inc   = ADDR_NUM ? (ptr_q + 16'd1) : {8'h00, ptr_q[7:0] + 8'd1};

  assign i2c_sda         = sda_oe_q ? 1'b0 : 1'bz;
  assign busy            = busy_q;
  assign mem.mem_wr_en   = mem_wr_en_q;
  assign mem.mem_rd_en   = mem_rd_en_q;
  assign mem.mem_addr    = mem_addr_q;
  assign mem.mem_wr_data = mem_wr_data_q;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      // Synchronisers preset high: an idle bus, so release cannot fake a START.
      scl_s1_q      <= 1'b1;
      scl_s2_q      <= 1'b1;
      scl_prev_q    <= 1'b1;
      sda_s1_q      <= 1'b1;
      sda_s2_q      <= 1'b1;
      sda_prev_q    <= 1'b1;
      state_q       <= IDLE;
      bit_cnt_q     <= 4'd0;
      shift_q       <= 8'h00;
      ptr_q         <= 16'h0000;
      sda_oe_q      <= 1'b0;
      busy_q        <= 1'b0;
      master_ack_q  <= 1'b0;
      rd_phase_q    <= 2'd0;
      mem_wr_en_q   <= 1'b0;
      mem_rd_en_q   <= 1'b0;
      mem_addr_q    <= 16'h0000;
      mem_wr_data_q <= 8'h00;
    end else begin
      scl_s1_q   <= i2c_scl;
      scl_s2_q   <= scl_s1_q;
      scl_prev_q <= scl_s2_q;
      sda_s1_q   <= i2c_sda;
      sda_s2_q   <= sda_s1_q;
      sda_prev_q <= sda_s2_q;

      mem_wr_en_q <= 1'b0;
      mem_rd_en_q <= 1'b0;

      // Read fetch: strobe issued at phase 0->1, data valid one cycle after
      // the strobe, latched and first bit driven in phase 2.
      if (rd_phase_q == 2'd1) begin
        rd_phase_q <= 2'd2;
      end else if (rd_phase_q == 2'd2) begin
        shift_q    <= mem.mem_rd_data;
        sda_oe_q   <= ~mem.mem_rd_data[7];
        rd_phase_q <= 2'd0;
      end

      if (start_det) begin
        state_q    <= DEV_ADDR;
        bit_cnt_q  <= 4'd0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b1;
        rd_phase_q <= 2'd0;
      end else if (stop_det) begin
        state_q    <= IDLE;
        bit_cnt_q  <= 4'd0;
        sda_oe_q   <= 1'b0;
        busy_q     <= 1'b0;
        rd_phase_q <= 2'd0;
      end else begin
        case (state_q)
          IDLE: ;

          DEV_ADDR, ADDR_H, ADDR_L, WR_DATA: begin
            if (scl_rise && bit_cnt_q < 4'd8) begin
              shift_q   <= byte_in;
              bit_cnt_q <= bit_cnt_q + 4'd1;
              if (bit_cnt_q == 4'd7) begin
                if (state_q == ADDR_H) begin
                  ptr_q[15:8] <= byte_in;
                end else if (state_q == ADDR_L) begin
                  ptr_q <= {(ADDR_NUM ? ptr_q[15:8] : 8'h00), byte_in};
                end else if (state_q == WR_DATA) begin
                  mem_wr_en_q   <= 1'b1;
                  mem_addr_q    <= ptr_q;
                  mem_wr_data_q <= byte_in;
                  ptr_q         <= ptr_inc;
                end
              end
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= 4'd0;
              if (state_q == DEV_ADDR && shift_q[7:1] != DEVICE_ADDR) begin
                state_q <= IDLE;
              end else begin
                sda_oe_q <= 1'b1;
                case (state_q)
                  DEV_ADDR: state_q <= ACK_DEV;
                  ADDR_H:   state_q <= ACK_AH;
                  ADDR_L:   state_q <= ACK_AL;
                  default:  state_q <= ACK_WR;
                endcase
              end
            end
          end

          ACK_DEV: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              if (shift_q[0]) begin
                state_q     <= RD_DATA;
                mem_rd_en_q <= 1'b1;
                mem_addr_q  <= ptr_q;
                ptr_q       <= ptr_inc;
                rd_phase_q  <= 2'd1;
              end else begin
                state_q <= ADDR_NUM ? ADDR_H : ADDR_L;
              end
            end
          end

          ACK_AH: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= ADDR_L;
            end
          end

          ACK_AL, ACK_WR: begin
            if (scl_fall) begin
              sda_oe_q <= 1'b0;
              state_q  <= WR_DATA;
            end
          end

          RD_DATA: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              if (bit_cnt_q == 4'd8) begin
                state_q   <= RD_ACK;
                sda_oe_q  <= 1'b0;
                bit_cnt_q <= 4'd0;
              end else begin
                shift_q  <= {shift_q[6:0], 1'b0};
                sda_oe_q <= ~shift_q[6];
              end
            end
          end

          RD_ACK: begin
            if (scl_rise) begin
              master_ack_q <= ~sda_s2_q;
            end else if (scl_fall) begin
              if (master_ack_q) begin
                state_q     <= RD_DATA;
                mem_rd_en_q <= 1'b1;
                mem_addr_q  <= ptr_q;
                ptr_q       <= ptr_inc;
                rd_phase_q  <= 2'd1;
              end else begin
                // NACK: stay off the bus until STOP or START.
                state_q <= IDLE;
              end
            end
          end

          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_eeprom_slave.sv
module tb_i2c_eeprom_slave;

  logic sys_clk = 1'b0;
  logic sys_rst_n;
  logic scl_m;
  logic sda_oe_m;
  logic busy;
  wire  i2c_sda;

  always #10 sys_clk = ~sys_clk;

  assign i2c_sda = sda_oe_m ? 1'b0 : 1'bz;
  pullup (i2c_sda);

  i2c_eeprom_slave_if mif ();

  i2c_eeprom_slave #(.DEVICE_ADDR(7'b1010_011), .ADDR_NUM(1'b1)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .i2c_scl   (scl_m),
    .i2c_sda   (i2c_sda),
    .mem       (mif),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [7:0]  data;
  } ev_t;

  ev_t         exp_q[$];
  ev_t         got_ev;
  logic [7:0]  mem_dev [int];
  logic [7:0]  mem_ref [int];
  logic [15:0] ptr_m = 16'h0000;

  // Content of a never-written memory location.
  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [15:0] a);
    return mem_ref.exists(int'(a)) ? mem_ref[int'(a)] : init_val(a);
  endfunction

  function automatic void push_ev(input bit w, input logic [15:0] a, input logic [7:0] d);
    ev_t e;
    e.is_wr = w;
    e.addr  = a;
    e.data  = d;
    exp_q.push_back(e);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory behind the DUT: read data presented the cycle after the strobe.
  always @(negedge sys_clk) begin
    if (mif.mem_wr_en) mem_dev[int'(mif.mem_addr)] = mif.mem_wr_data;
    if (mif.mem_rd_en)
      mif.mem_rd_data = mem_dev.exists(int'(mif.mem_addr)) ? mem_dev[int'(mif.mem_addr)]
                                                           : init_val(mif.mem_addr);
  end

  // Scoreboard monitor.
  always @(negedge sys_clk) begin
    if (mif.mem_wr_en && mif.mem_rd_en) begin
      n_checks++;
      n_errors++;
      $display("FAIL strobe_excl: both strobes high addr=%h", mif.mem_addr);
    end else if (mif.mem_wr_en || mif.mem_rd_en) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected_strobe: wr=%0b addr=%h data=%h, none expected",
                 mif.mem_wr_en, mif.mem_addr, mif.mem_wr_data);
      end else begin
        got_ev = exp_q.pop_front();
        if (got_ev.is_wr != mif.mem_wr_en || got_ev.addr != mif.mem_addr ||
            (got_ev.is_wr && got_ev.data != mif.mem_wr_data)) begin
          n_errors++;
          $display("FAIL strobe: got wr=%0b addr=%h data=%h expected wr=%0b addr=%h data=%h",
                   mif.mem_wr_en, mif.mem_addr, mif.mem_wr_data,
                   got_ev.is_wr, got_ev.addr, got_ev.data);
        end
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_oe_m = 1'b0; wait_clk(5);
    scl_m = 1'b1;    wait_clk(10);
    sda_oe_m = 1'b1; wait_clk(10);
    scl_m = 1'b0;    wait_clk(5);
  endtask

  task automatic i2c_stop();
    sda_oe_m = 1'b1; wait_clk(5);
    scl_m = 1'b1;    wait_clk(10);
    sda_oe_m = 1'b0; wait_clk(10);
  endtask

  task automatic send_bit(input logic b);
    sda_oe_m = ~b; wait_clk(5);
    scl_m = 1'b1;  wait_clk(10);
    scl_m = 1'b0;  wait_clk(5);
  endtask

  task automatic recv_bit(output logic b);
    sda_oe_m = 1'b0; wait_clk(5);
    scl_m = 1'b1;    wait_clk(5);
    b = i2c_sda;     wait_clk(5);
    scl_m = 1'b0;    wait_clk(5);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    ack = ~b;
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack_m);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      recv_bit(b);
      d = {d[6:0], b};
    end
    send_bit(~ack_m);
  endtask

  // START, device write address, word address, data bytes, optional STOP.
  task automatic write_bytes(input logic [15:0] addr, input logic [7:0] data[$], input bit do_stop);
    logic ack;
    i2c_start();
    send_byte(8'hA6, ack);       chk("wr_dev_ack", ack, 1);
    send_byte(addr[15:8], ack);  chk("addr_h_ack", ack, 1);
    send_byte(addr[7:0], ack);   chk("addr_l_ack", ack, 1);
    ptr_m = addr;
    foreach (data[i]) begin
      push_ev(1'b1, ptr_m, data[i]);
      mem_ref[int'(ptr_m)] = data[i];
      send_byte(data[i], ack);
      chk("wr_data_ack", ack, 1);
      ptr_m = ptr_m + 16'd1;
    end
    if (do_stop) i2c_stop();
  endtask

  // Current-address read of n bytes after a START already on the bus.
  task automatic read_cur(input int n);
    logic       ack;
    logic [7:0] d, e;
    push_ev(1'b0, ptr_m, 8'h00);
    send_byte(8'hA7, ack);
    chk("rd_dev_ack", ack, 1);
    for (int i = 0; i < n; i++) begin
      e = ref_rd(ptr_m);
      ptr_m = ptr_m + 16'd1;
      if (i < n - 1) push_ev(1'b0, ptr_m, 8'h00);
      recv_byte(d, i < n - 1);
      chk("rd_data", d, e);
    end
  endtask

  logic [7:0]  dq[$];
  logic        ack_v, bit_v;
  logic [15:0] ra;
  int          op, nb;

  initial begin
    sys_rst_n = 1'b0;
    scl_m     = 1'b1;
    sda_oe_m  = 1'b0;
    wait_clk(5);
    chk("rst_wr_en",   mif.mem_wr_en, 0);
    chk("rst_rd_en",   mif.mem_rd_en, 0);
    chk("rst_addr",    mif.mem_addr, 0);
    chk("rst_wr_data", mif.mem_wr_data, 0);
    chk("rst_busy",    busy, 0);
    chk("rst_sda",     i2c_sda, 1);
    sys_rst_n = 1'b1;
    wait_clk(10);

    // Random read of 0x0012 holding 0x3C, then confirm pointer moved to 0x0013.
    dq = {}; dq.push_back(8'h3C);
    write_bytes(16'h0012, dq, 1'b1);
    dq = {};
    write_bytes(16'h0012, dq, 1'b0);
    i2c_start(); read_cur(1); i2c_stop();
    chk("ptr_after_read", ptr_m, 16'h0013);
    i2c_start(); read_cur(1); i2c_stop();

    // Single write, busy across the transaction.
    dq = {}; dq.push_back(8'h5A);
    write_bytes(16'h0012, dq, 1'b0);
    chk("busy_in_xfer", busy, 1);
    i2c_stop();
    chk("busy_after_stop", busy, 0);

    // Sequential read wrapping from 0xFFFF.
    dq = {};
    write_bytes(16'hFFFF, dq, 1'b0);
    i2c_start(); read_cur(3); i2c_stop();

    // Wrong device address: nothing acknowledged, no strobes.
    i2c_start();
    send_byte(8'hA0, ack_v); chk("mismatch_nack", ack_v, 0);
    send_byte(8'h00, ack_v); chk("ignored_nack0", ack_v, 0);
    send_byte(8'h12, ack_v); chk("ignored_nack1", ack_v, 0);
    send_byte(8'h55, ack_v); chk("ignored_nack2", ack_v, 0);
    i2c_stop();

    // STOP after 5 bits of a data byte: no write, pointer kept.
    dq = {};
    write_bytes(16'h0040, dq, 1'b0);
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    i2c_stop();
    chk("busy_after_abort", busy, 0);
    i2c_start(); read_cur(1); i2c_stop();

    // Reset pulse while a 0x00 byte is being driven.
    dq = {}; dq.push_back(8'h00);
    write_bytes(16'h0100, dq, 1'b1);
    dq = {};
    write_bytes(16'h0100, dq, 1'b0);
    i2c_start();
    push_ev(1'b0, 16'h0100, 8'h00);
    send_byte(8'hA7, ack_v); chk("rst_rd_dev_ack", ack_v, 1);
    for (int i = 0; i < 3; i++) recv_bit(bit_v);
    chk("sda_low_before_rst", i2c_sda, 0);
    sys_rst_n = 1'b0;
    wait_clk(1);
    chk("sda_released_rst", i2c_sda, 1);
    chk("mid_rst_outputs", {mif.mem_wr_en, mif.mem_rd_en, busy, mif.mem_addr, mif.mem_wr_data}, 0);
    sys_rst_n = 1'b1;
    ptr_m = 16'h0000;
    wait_clk(5);
    i2c_stop();
    dq = {}; dq.push_back(8'($urandom)); dq.push_back(8'($urandom));
    write_bytes(16'($urandom), dq, 1'b1);
    i2c_start(); read_cur(1); i2c_stop();

    // Randomised mix of writes, random reads and current-address reads.
    for (int it = 0; it < 12; it++) begin
      op = $urandom_range(0, 2);
      nb = $urandom_range(1, 4);
      ra = 16'($urandom);
      if ($urandom_range(0, 3) == 0) ra = 16'hFFFE;
      if (op == 0) begin
        dq = {};
        for (int k = 0; k < nb; k++) dq.push_back(8'($urandom));
        write_bytes(ra, dq, 1'b1);
      end else if (op == 1) begin
        dq = {};
        write_bytes(ra, dq, 1'b0);
        i2c_start(); read_cur(nb); i2c_stop();
      end else begin
        i2c_start(); read_cur(nb); i2c_stop();
      end
    end

    wait_clk(20);
    chk("scoreboard_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/i2c_eeprom_slave.md
I2C_EEPROM_SLAVE -- requirements
Module: i2c_eeprom_slave

Interface
REQ-001 SHALL have parameter DEVICE_ADDR, default 7'b1010_011, the 7-bit address this responder answers to.
REQ-002 SHALL have parameter ADDR_NUM, default 1'b1, selecting the word-address length: 0 = 1 byte, 1 = 2 bytes (high byte first).
REQ-003 SHALL have port sys_clk  input  1  system clock, 50 MHz, the only clock in the block.
REQ-004 SHALL have port sys_rst_n  input  1  reset, synchronous to sys_clk, active-low.
REQ-005 SHALL have port i2c_scl  input  1  bus clock, asynchronous to sys_clk.
REQ-006 SHALL have port i2c_sda  inout  1  bus data, open-drain: the block drives only 0 or Z.
REQ-007 SHALL have port mem_wr_en  output  1  one-cycle memory write strobe.
REQ-008 SHALL have port mem_rd_en  output  1  one-cycle memory read strobe.
REQ-009 SHALL have port mem_addr  output  16  memory byte address.
REQ-010 SHALL have port mem_wr_data  output  8  memory write data.
REQ-011 SHALL have port mem_rd_data  input  8  memory read data, valid 1 cycle after mem_rd_en.
REQ-012 SHALL have port busy  output  1  high from a detected START until a detected STOP.

Function
REQ-013 SHALL synchronise i2c_scl and the sampled i2c_sda through 2 flip-flops each, and edge-detect the synchronised values.
REQ-014 SHALL detect START as a synced SDA fall while synced SCL is high, and STOP as a synced SDA rise while synced SCL is high.
REQ-015 SHALL sample SDA on SCL rising edges, change its SDA drive only after SCL falling edges, and update drive within 3 sys_clk cycles of the synced SCL fall.
REQ-016 SHALL have FSM states IDLE, DEV_ADDR, ACK_DEV, ADDR_H, ACK_AH, ADDR_L, ACK_AL, WR_DATA, ACK_WR, RD_DATA, RD_ACK.
REQ-017 SHALL transition from any state to DEV_ADDR on START (including repeated START), clearing the bit counter.
REQ-018 SHALL transition from any state to IDLE on STOP, releasing SDA.
REQ-019 SHALL, in DEV_ADDR, shift in 8 bits MSB first and compare the top 7 bits with DEVICE_ADDR.
REQ-020 SHALL, on a DEV_ADDR mismatch, leave SDA released on the 9th clock, go to IDLE, and ignore the bus until the next START.
REQ-021 SHALL, on a DEV_ADDR match, drive ACK (SDA=0) on the 9th clock.
REQ-022 SHALL, after the device-address ACK with R/W=0, go to ADDR_H when ADDR_NUM=1, else to ADDR_L.
REQ-023 SHALL, after the device-address ACK with R/W=1, go to RD_DATA using the current address pointer (current-address read).
REQ-024 SHALL ACK every word-address byte, load it into the 16-bit pointer, and force pointer[15:8]=0 when ADDR_NUM=0.
REQ-025 SHALL, after the address bytes, receive data bytes in WR_DATA and ACK each one.
REQ-026 SHALL, on the 8th SCL rise of each WR_DATA byte, pulse mem_wr_en for 1 cycle with mem_addr=pointer and mem_wr_data=the received byte, then increment the pointer.
REQ-027 SHALL, on entry to RD_DATA, pulse mem_rd_en with mem_addr=pointer, latch mem_rd_data into the shift register on the next cycle, and increment the pointer.
REQ-028 SHALL drive the 8 read bits MSB first, releasing SDA for each 1 bit.
REQ-029 SHALL release SDA in RD_ACK and sample the master's response: ACK (0) returns to RD_DATA with the next byte; NACK (1) waits, SDA released, for STOP or START.
REQ-030 SHALL wrap the pointer from 0xFFFF to 0x0000, or from 0x00FF to 0x0000 when ADDR_NUM=0.
REQ-031 SHALL leave a byte interrupted by START or STOP before its 8th bit without a memory write, and leave the pointer unchanged.
REQ-032 SHALL keep mem_wr_en and mem_rd_en mutually exclusive, never asserting them in the same cycle.
REQ-033 SHALL operate correctly with SCL high and low times of 8 sys_clk cycles or more each; the 250 kHz SCL from a 50 MHz clock meets this.

Reset
REQ-034 SHALL, when sys_rst_n=0 at a sys_clk edge, set the FSM to IDLE, release SDA (Z), clear the pointer, bit counter and shift registers to 0, and drive mem_wr_en=0, mem_rd_en=0, mem_addr=0, mem_wr_data=0, busy=0.
REQ-035 SHALL, on reset mid-transfer, abort the transfer silently, with no strobes and no ACK, until the next START after reset release.
REQ-036 SHALL preset the synchroniser flip-flops to 1 during reset so that bus idle is seen and no false START is detected.

Verification
REQ-037 SHALL cover this write: START, 0xA6, 0x00, 0x12, 0x5A, STOP -> 4 ACKs; one mem_wr_en pulse with mem_addr=0x0012 and mem_wr_data=0x5A; busy falls after STOP.
REQ-038 SHALL cover this random read: write address 0x0012, repeated START, 0xA7, mem_rd_data=0x3C -> the slave shifts out 0x3C; master NACK then STOP -> IDLE, pointer=0x0013.
REQ-039 SHALL cover this sequential read wrap: pointer 0xFFFF, 3 bytes read with ACK, ACK, NACK -> mem_addr sequence 0xFFFF, 0x0000, 0x0001.
REQ-040 SHALL cover this address mismatch: START, 0xA0 -> SDA stays Z on the 9th clock; no mem strobes until the next START.
REQ-041 SHALL cover a STOP after 5 bits of a WR_DATA byte -> no mem_wr_en pulse; pointer unchanged; FSM in IDLE.
REQ-042 SHALL cover sys_rst_n low for 1 cycle during a RD_DATA bit -> SDA released within 1 cycle, all outputs 0, and the next transaction is fully ACKed.
